conexao_sensor_multicanal: RTL and testbench



---
 rtl/conexao_sensor_multicanal.sv | 259 +++++++++++++++++++++++++
 tb/tb_conexao_sensor_multicanal.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conexao_sensor_multicanal.sv
// Multi-channel sensor request handler: decodes (command, address) requests, runs one
// checked read per request with timeout, and drives periodic reads in continuous mode.
module conexao_sensor_multicanal #(
    parameter int NUM_SENSORES    = 4,
    parameter int PERIODO_LOOP    = 125000000,
    parameter int TIMEOUT_LEITURA = 5000000,
    parameter int LARGURA_CONT    = 27
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [7:0]                   request_command,
    input  logic [7:0]                   request_address,
    input  logic [40*NUM_SENSORES-1:0]   sensor_data,
    input  logic [NUM_SENSORES-1:0]      sensor_error,
    input  logic [NUM_SENSORES-1:0]      sensor_done,
    output logic [NUM_SENSORES-1:0]      sensor_enable,
    output logic                         dadosPodemSerEnviados,
    output logic [7:0]                   response_command,
    output logic [7:0]                   response_value
);

    localparam int LARG_CH = (NUM_SENSORES > 1) ? $clog2(NUM_SENSORES) : 1;
    localparam logic [LARGURA_CONT-1:0] LIM_PERIODO = LARGURA_CONT'(PERIODO_LOOP - 1);
    localparam logic [LARGURA_CONT-1:0] LIM_TIMEOUT = LARGURA_CONT'(TIMEOUT_LEITURA - 1);
    localparam logic [LARGURA_CONT-1:0] UM_CONT     = LARGURA_CONT'(1);
    localparam logic [NUM_SENSORES-1:0] UM_CH       = NUM_SENSORES'(1);
    localparam logic [7:0]              NUM_CH      = 8'(NUM_SENSORES);

    localparam logic [7:0] CMD_STATUS    = 8'hAC;
    localparam logic [7:0] CMD_TEMP      = 8'h01;
    localparam logic [7:0] CMD_UMID      = 8'h02;
    localparam logic [7:0] CMD_LOOP_TEMP = 8'h03;
    localparam logic [7:0] CMD_LOOP_UMID = 8'h04;
    localparam logic [7:0] CMD_PARA_TEMP = 8'h05;
    localparam logic [7:0] CMD_PARA_UMID = 8'h06;
    localparam logic [7:0] RSP_ERRO      = 8'h1F;

    typedef enum logic [2:0] {
        ESPERA,
        LEITURA,
        ENVIO,
        LOOP_ESPERA,
        LOOP_LEITURA
    } estado_t;

    estado_t                    state_q, state_d;
    logic [7:0]                 cmd_q, cmd_d;
    logic [LARG_CH-1:0]         ch_q, ch_d;
    logic                       loop_ativo_q, loop_ativo_d;
    logic [7:0]                 loop_cmd_q, loop_cmd_d;
    logic [LARG_CH-1:0]         loop_ch_q, loop_ch_d;
    logic [LARGURA_CONT-1:0]    cont_q, cont_d;
    logic                       manter_cont_q, manter_cont_d;
    logic [7:0]                 resp_cmd_q, resp_cmd_d;
    logic [7:0]                 resp_val_q, resp_val_d;
    logic [NUM_SENSORES-1:0]    sensor_enable_q, sensor_enable_d;
    logic                       valid_q, valid_d;
    logic [7:0]                 response_command_q, response_command_d;
    logic [7:0]                 response_value_q, response_value_d;

    logic [LARG_CH-1:0]         sel_ch_s;
    logic [7:0]                 sel_cmd_s;
    logic [39:0]                frame_s;
    logic                       done_s;
    logic                       erro_s;
    logic [15:0]                resultado_s;

    function automatic logic checksum_ok(input logic [39:0] q);
        logic [7:0] soma;
        soma = q[39:32] + q[31:24] + q[23:16] + q[15:8];
        return (q[7:0] == soma);
    endfunction

    function automatic logic [15:0] resultado_leitura(input logic [7:0] cmd,
                                                      input logic [39:0] q,
                                                      input logic erro);
        logic [15:0] r;
        r = {RSP_ERRO, RSP_ERRO};
        if (!erro && checksum_ok(q)) begin
            case (cmd)
                CMD_STATUS:    r = {8'h07, 8'h07};
                CMD_TEMP:      r = {8'h09, q[23:16]};
                CMD_UMID:      r = {8'h08, q[39:32]};
                CMD_LOOP_TEMP: r = {8'h0D, q[23:16]};
                CMD_LOOP_UMID: r = {8'h0E, q[39:32]};
                default:       r = {RSP_ERRO, RSP_ERRO};
            endcase
        end else begin
            r = {RSP_ERRO, RSP_ERRO};
        end
        return r;
    endfunction

    // Select the frame and flags of the channel currently being read
    always_comb begin
        sel_ch_s  = (state_q == LOOP_LEITURA) ? loop_ch_q  : ch_q;
        sel_cmd_s = (state_q == LOOP_LEITURA) ? loop_cmd_q : cmd_q;
        frame_s   = 40'd0;
        done_s    = 1'b0;
        erro_s    = 1'b0;
        for (int k = 0; k < NUM_SENSORES; k++) begin
            frame_s = frame_s | ((sel_ch_s == LARG_CH'(k)) ? sensor_data[k*40 +: 40] : 40'd0);
            done_s  = done_s  | ((sel_ch_s == LARG_CH'(k)) ? sensor_done[k]  : 1'b0);
            erro_s  = erro_s  | ((sel_ch_s == LARG_CH'(k)) ? sensor_error[k] : 1'b0);
        end
        resultado_s = resultado_leitura(sel_cmd_s, frame_s, erro_s);
    end

    // Next-state and output decisions
    always_comb begin
        state_d            = state_q;
        cmd_d              = cmd_q;
        ch_d               = ch_q;
        loop_ativo_d       = loop_ativo_q;
        loop_cmd_d         = loop_cmd_q;
        loop_ch_d          = loop_ch_q;
        cont_d             = cont_q;
        manter_cont_d      = manter_cont_q;
        resp_cmd_d         = resp_cmd_q;
        resp_val_d         = resp_val_q;
        sensor_enable_d    = sensor_enable_q;
        valid_d            = 1'b0;
        response_command_d = response_command_q;
        response_value_d   = response_value_q;

        case (state_q)
            ESPERA: begin
                if (enable) begin
                    cmd_d         = request_command;
                    ch_d          = request_address[LARG_CH-1:0];
                    manter_cont_d = 1'b0;
                    if (request_address >= NUM_CH) begin
                        {resp_cmd_d, resp_val_d} = {8'hEA, 8'hEA};
                        state_d = ENVIO;
                    end else if (request_command == CMD_PARA_TEMP || request_command == CMD_PARA_UMID) begin
                        {resp_cmd_d, resp_val_d} = {8'hAA, 8'hAA};
                        state_d = ENVIO;
                    end else if (request_command == CMD_LOOP_TEMP || request_command == CMD_LOOP_UMID) begin
                        loop_ativo_d = 1'b1;
                        loop_cmd_d   = request_command;
                        loop_ch_d    = request_address[LARG_CH-1:0];
                        cont_d       = '0;
                        state_d      = LOOP_ESPERA;
                    end else if (request_command == CMD_STATUS || request_command == CMD_TEMP ||
                                 request_command == CMD_UMID) begin
                        sensor_enable_d = UM_CH << request_address[LARG_CH-1:0];
                        cont_d          = '0;
                        state_d         = LEITURA;
                    end else begin
                        {resp_cmd_d, resp_val_d} = {8'h45, 8'h45};
                        state_d = ENVIO;
                    end
                end else begin
                    state_d = ESPERA;
                end
            end

            // Done is checked before timeout so a simultaneous done wins
            LEITURA, LOOP_LEITURA: begin
                if (done_s) begin
                    {resp_cmd_d, resp_val_d} = resultado_s;
                    sensor_enable_d = '0;
                    manter_cont_d   = 1'b0;
                    state_d         = ENVIO;
                end else if (cont_q >= LIM_TIMEOUT) begin
                    {resp_cmd_d, resp_val_d} = {RSP_ERRO, RSP_ERRO};
                    sensor_enable_d = '0;
                    manter_cont_d   = 1'b0;
                    state_d         = ENVIO;
                end else begin
                    cont_d = cont_q + UM_CONT;
                end
            end

            ENVIO: begin
                response_command_d = resp_cmd_q;
                response_value_d   = resp_val_q;
                valid_d            = 1'b1;
                cont_d             = manter_cont_q ? (cont_q + UM_CONT) : '0;
                state_d            = loop_ativo_q ? LOOP_ESPERA : ESPERA;
            end

            // A rejected request keeps the period running through its own response
            LOOP_ESPERA: begin
                if (enable) begin
                    if (request_command == CMD_PARA_TEMP && loop_cmd_q == CMD_LOOP_TEMP) begin
                        {resp_cmd_d, resp_val_d} = {8'h0A, 8'h0A};
                        loop_ativo_d  = 1'b0;
                        manter_cont_d = 1'b0;
                    end else if (request_command == CMD_PARA_UMID && loop_cmd_q == CMD_LOOP_UMID) begin
                        {resp_cmd_d, resp_val_d} = {8'h0B, 8'h0B};
                        loop_ativo_d  = 1'b0;
                        manter_cont_d = 1'b0;
                    end else begin
                        {resp_cmd_d, resp_val_d} = {8'hFF, 8'hFF};
                        manter_cont_d = 1'b1;
                    end
                    cont_d  = cont_q + UM_CONT;
                    state_d = ENVIO;
                end else if (cont_q >= LIM_PERIODO) begin
                    sensor_enable_d = UM_CH << loop_ch_q;
                    cont_d          = '0;
                    state_d         = LOOP_LEITURA;
                end else begin
                    cont_d = cont_q + UM_CONT;
                end
            end

            default: begin
                sensor_enable_d = '0;
                loop_ativo_d    = 1'b0;
                cont_d          = '0;
                state_d         = ESPERA;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q            <= ESPERA;
            cmd_q              <= 8'h00;
            ch_q               <= '0;
            loop_ativo_q       <= 1'b0;
            loop_cmd_q         <= 8'h00;
            loop_ch_q          <= '0;
            cont_q             <= '0;
            manter_cont_q      <= 1'b0;
            resp_cmd_q         <= 8'h00;
            resp_val_q         <= 8'h00;
            sensor_enable_q    <= '0;
            valid_q            <= 1'b0;
            response_command_q <= 8'h00;
            response_value_q   <= 8'h00;
        end else begin
            state_q            <= state_d;
            cmd_q              <= cmd_d;
            ch_q               <= ch_d;
            loop_ativo_q       <= loop_ativo_d;
            loop_cmd_q         <= loop_cmd_d;
            loop_ch_q          <= loop_ch_d;
            cont_q             <= cont_d;
            manter_cont_q      <= manter_cont_d;
            resp_cmd_q         <= resp_cmd_d;
            resp_val_q         <= resp_val_d;
            sensor_enable_q    <= sensor_enable_d;
            valid_q            <= valid_d;
            response_command_q <= response_command_d;
            response_value_q   <= response_value_d;
        end
    end

    assign sensor_enable         = sensor_enable_q;
    assign dadosPodemSerEnviados = valid_q;
    assign response_command      = response_command_q;
    assign response_value        = response_value_q;

endmodule

// File: tb/tb_conexao_sensor_multicanal.sv
// Scoreboard bench for conexao_sensor_multicanal: expected responses are queued when a
// request is issued and compared when the response-valid pulse appears.
module tb_conexao_sensor_multicanal;

    localparam int NS  = 4;
    localparam int PER = 50;
    localparam int TMO = 100;
    localparam int ATR = 3;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [7:0]        request_command = 8'h00;
    logic [7:0]        request_address = 8'h00;
    logic [40*NS-1:0]  sensor_data = '0;
    logic [NS-1:0]     sensor_error = '0;
    logic [NS-1:0]     sensor_done = '0;
    logic [NS-1:0]     sensor_enable;
    logic              dadosPodemSerEnviados;
    logic [7:0]        response_command;
    logic [7:0]        response_value;

    int          n_checks = 0;
    int          n_pass = 0;
    int          ciclo = 0;
    int          pulsos = 0;
    int          ciclo_pulso = 0;
    logic        valid_ant = 1'b0;
    logic [15:0] esperados[$];
    int          atraso[NS];
    int          cont_sens[NS];

    conexao_sensor_multicanal #(
        .NUM_SENSORES    (NS),
        .PERIODO_LOOP    (PER),
        .TIMEOUT_LEITURA (TMO),
        .LARGURA_CONT    (27)
    ) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .enable                (enable),
        .request_command       (request_command),
        .request_address       (request_address),
        .sensor_data           (sensor_data),
        .sensor_error          (sensor_error),
        .sensor_done           (sensor_done),
        .sensor_enable         (sensor_enable),
        .dadosPodemSerEnviados (dadosPodemSerEnviados),
        .response_command      (response_command),
        .response_value        (response_value)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        ciclo++;
    end

    // Sensor front-end model: done pulses atraso[k] cycles after enable rises (0 = never)
    initial begin
        for (int k = 0; k < NS; k++) begin
            atraso[k] = ATR;
            cont_sens[k] = 0;
        end
        forever begin
            @(negedge clock);
            for (int k = 0; k < NS; k++) begin
                if (sensor_enable[k] === 1'b1 && atraso[k] > 0) begin
                    cont_sens[k]++;
                    sensor_done[k] = (cont_sens[k] == atraso[k]);
                end else begin
                    cont_sens[k] = 0;
                    sensor_done[k] = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every valid pulse
    initial forever begin
        logic [15:0] exp_v;
        @(posedge clock);
        #2;
        if (dadosPodemSerEnviados === 1'b1) begin
            pulsos++;
            ciclo_pulso = ciclo;
            n_checks++;
            if (esperados.size() == 0) begin
                $display("FAIL resposta_inesperada: got %h/%h, expected no response at cycle %0d",
                         response_command, response_value, ciclo);
            end else begin
                exp_v = esperados.pop_front();
                if ({response_command, response_value} !== exp_v)
                    $display("FAIL resposta: got %h/%h, expected %h/%h at cycle %0d",
                             response_command, response_value, exp_v[15:8], exp_v[7:0], ciclo);
                else
                    n_pass++;
            end
            n_checks++;
            if (valid_ant === 1'b1)
                $display("FAIL pulso_consecutivo: valid high in two consecutive cycles at cycle %0d", ciclo);
            else
                n_pass++;
        end
        valid_ant = dadosPodemSerEnviados;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles", ciclo);
        $fatal(1);
    end

    task automatic requisita(input logic [7:0] cmd, input logic [7:0] addr, output int n);
        @(negedge clock);
        request_command = cmd;
        request_address = addr;
        enable = 1'b1;
        n = ciclo + 1;
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic espera_pulso(input int alvo, input int limite, input string nome);
        int i;
        i = 0;
        while (pulsos < alvo && i < limite) begin
            @(negedge clock);
            i++;
        end
        n_checks++;
        if (pulsos < alvo)
            $display("FAIL %s_espera: got %0d pulses, expected %0d within %0d cycles", nome, pulsos, alvo, limite);
        else
            n_pass++;
    endtask

    task automatic define_quadro(input int k, input logic [39:0] q);
        sensor_data[k*40 +: 40] = q;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (sensor_enable !== 4'b0000) $display("FAIL reset_enable: got %b, expected 0000", sensor_enable);
        else n_pass++;
        n_checks++;
        if (dadosPodemSerEnviados !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", dadosPodemSerEnviados);
        else n_pass++;
        n_checks++;
        if (response_command !== 8'h00) $display("FAIL reset_cmd: got %h, expected 00", response_command);
        else n_pass++;
        n_checks++;
        if (response_value !== 8'h00) $display("FAIL reset_val: got %h, expected 00", response_value);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_leitura_ok();
        int n, p;
        define_quadro(2, 40'h2D_00_19_00_46);
        p = pulsos;
        esperados.push_back({8'h09, 8'h19});
        requisita(8'h01, 8'h02, n);
        n_checks++;
        if (sensor_enable !== 4'b0100) $display("FAIL leitura_enable: got %b, expected 0100", sensor_enable);
        else n_pass++;
        espera_pulso(p + 1, 50, "leitura_ok");
        n_checks++;
        if (ciclo_pulso !== n + ATR + 1)
            $display("FAIL leitura_latencia: got cycle %0d, expected %0d", ciclo_pulso, n + ATR + 1);
        else n_pass++;
        n_checks++;
        if (sensor_enable !== 4'b0000) $display("FAIL leitura_enable_cai: got %b, expected 0000", sensor_enable);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (dadosPodemSerEnviados !== 1'b0) $display("FAIL leitura_pulso_unico: got %b, expected 0", dadosPodemSerEnviados);
        else n_pass++;
    endtask

    task automatic test_erros();
        int n, p;
        p = pulsos;
        define_quadro(2, 40'h2D_00_19_00_47);
        esperados.push_back({8'h1F, 8'h1F});
        requisita(8'h02, 8'h02, n);
        espera_pulso(p + 1, 50, "erro_checksum");
        define_quadro(1, 40'h2D_00_19_00_46);
        sensor_error = 4'b0010;
        esperados.push_back({8'h1F, 8'h1F});
        requisita(8'hAC, 8'h01, n);
        espera_pulso(p + 2, 50, "erro_protocolo");
        sensor_error = 4'b0000;
        esperados.push_back({8'h07, 8'h07});
        requisita(8'hAC, 8'h01, n);
        espera_pulso(p + 3, 50, "status_ok");
    endtask

    task automatic test_imediatas();
        int n, p;
        logic [7:0] cmds[3];
        logic [7:0] ends[3];
        logic [15:0] rsp[3];
        cmds = '{8'h01, 8'h05, 8'h3C};
        ends = '{8'h07, 8'h00, 8'h00};
        rsp  = '{16'hEAEA, 16'hAAAA, 16'h4545};
        for (int i = 0; i < 3; i++) begin
            p = pulsos;
            esperados.push_back(rsp[i]);
            requisita(cmds[i], ends[i], n);
            n_checks++;
            if (sensor_enable !== 4'b0000)
                $display("FAIL imediata_enable_%0d: got %b, expected 0000", i, sensor_enable);
            else n_pass++;
            espera_pulso(p + 1, 20, "imediata");
            n_checks++;
            if (ciclo_pulso !== n + 1)
                $display("FAIL imediata_latencia_%0d: got cycle %0d, expected %0d", i, ciclo_pulso, n + 1);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int n, p, alto;
        atraso[0] = 0;
        define_quadro(0, 40'h2D_00_19_00_46);
        p = pulsos;
        esperados.push_back({8'h1F, 8'h1F});
        requisita(8'h01, 8'h00, n);
        alto = 0;
        for (int i = 0; i < 3 * TMO && sensor_enable[0] === 1'b1; i++) begin
            alto++;
            @(negedge clock);
        end
        n_checks++;
        if (alto !== TMO) $display("FAIL timeout_duracao: got %0d cycles, expected %0d", alto, TMO);
        else n_pass++;
        espera_pulso(p + 1, 10, "timeout");
        n_checks++;
        if (ciclo_pulso !== n + TMO + 1)
            $display("FAIL timeout_latencia: got cycle %0d, expected %0d", ciclo_pulso, n + TMO + 1);
        else n_pass++;
        n_checks++;
        if (sensor_enable !== 4'b0000) $display("FAIL timeout_enable: got %b, expected 0000", sensor_enable);
        else n_pass++;
        atraso[0] = ATR;
    endtask

    task automatic test_loop();
        int n, p, t_ant, en_vistos;
        define_quadro(3, 40'h30_00_15_00_45);
        p = pulsos;
        esperados.push_back({8'h0E, 8'h30});
        requisita(8'h04, 8'h03, n);
        n_checks++;
        if (sensor_enable !== 4'b0000) $display("FAIL loop_entrada_enable: got %b, expected 0000", sensor_enable);
        else n_pass++;
        espera_pulso(p + 1, 200, "loop_1");
        n_checks++;
        if (ciclo_pulso !== n + PER + ATR + 1)
            $display("FAIL loop_primeiro: got cycle %0d, expected %0d", ciclo_pulso, n + PER + ATR + 1);
        else n_pass++;
        t_ant = ciclo_pulso;
        for (int r = 2; r <= 3; r++) begin
            esperados.push_back({8'h0E, 8'h30});
            espera_pulso(p + r, 200, "loop_n");
            n_checks++;
            if (ciclo_pulso - t_ant !== PER + ATR + 1)
                $display("FAIL loop_periodo_%0d: got %0d cycles, expected %0d", r, ciclo_pulso - t_ant, PER + ATR + 1);
            else n_pass++;
            t_ant = ciclo_pulso;
        end
        esperados.push_back({8'hFF, 8'hFF});
        requisita(8'h01, 8'h00, n);
        espera_pulso(p + 4, 20, "loop_outro_cmd");
        esperados.push_back({8'h0E, 8'h30});
        espera_pulso(p + 5, 200, "loop_continua");
        n_checks++;
        if (ciclo_pulso - t_ant !== PER + ATR + 1)
            $display("FAIL loop_contador_mantido: got %0d cycles, expected %0d", ciclo_pulso - t_ant, PER + ATR + 1);
        else n_pass++;
        t_ant = ciclo_pulso;
        esperados.push_back({8'hFF, 8'hFF});
        requisita(8'h05, 8'h03, n);
        espera_pulso(p + 6, 20, "loop_parada_errada");
        esperados.push_back({8'h0E, 8'h30});
        espera_pulso(p + 7, 200, "loop_apos_parada_errada");
        esperados.push_back({8'h0B, 8'h0B});
        requisita(8'h06, 8'h03, n);
        espera_pulso(p + 8, 20, "loop_parada");
        n_checks++;
        if (ciclo_pulso !== n + 1)
            $display("FAIL loop_parada_latencia: got cycle %0d, expected %0d", ciclo_pulso, n + 1);
        else n_pass++;
        en_vistos = 0;
        repeat (3 * PER) begin
            @(negedge clock);
            if (sensor_enable !== 4'b0000) en_vistos++;
        end
        n_checks++;
        if (en_vistos !== 0) $display("FAIL loop_parado_enable: got %0d cycles enabled, expected 0", en_vistos);
        else n_pass++;
    endtask

    task automatic test_reset_loop();
        int n, p, i, en_vistos;
        atraso[1] = 0;
        define_quadro(1, 40'h2D_00_19_00_46);
        requisita(8'h03, 8'h01, n);
        i = 0;
        while (sensor_enable !== 4'b0010 && i < 200) begin
            @(negedge clock);
            i++;
        end
        n_checks++;
        if (sensor_enable !== 4'b0010) $display("FAIL reset_loop_leitura: got %b, expected 0010", sensor_enable);
        else n_pass++;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({sensor_enable, dadosPodemSerEnviados, response_command, response_value} !== 21'd0)
            $display("FAIL reset_loop_saidas: got en=%b v=%b %h/%h, expected all 0",
                     sensor_enable, dadosPodemSerEnviados, response_command, response_value);
        else n_pass++;
        reset_n = 1'b1;
        atraso[1] = ATR;
        p = pulsos;
        esperados.push_back({8'hAA, 8'hAA});
        requisita(8'h05, 8'h00, n);
        espera_pulso(p + 1, 20, "reset_loop_parada");
        n_checks++;
        if (ciclo_pulso !== n + 1)
            $display("FAIL reset_loop_latencia: got cycle %0d, expected %0d", ciclo_pulso, n + 1);
        else n_pass++;
        en_vistos = 0;
        repeat (2 * PER) begin
            @(negedge clock);
            if (sensor_enable !== 4'b0000) en_vistos++;
        end
        n_checks++;
        if (en_vistos !== 0) $display("FAIL reset_loop_sem_leitura: got %0d cycles enabled, expected 0", en_vistos);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_leitura_ok();
        test_erros();
        test_imediatas();
        test_timeout();
        test_loop();
        test_reset_loop();
        repeat (5) @(negedge clock);
        n_checks++;
        if (esperados.size() != 0)
            $display("FAIL scoreboard_vazio: got %0d pending responses, expected 0", esperados.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
